// File: rtl/multi_dac_sequencer_pkg.sv
// multi_dac_sequencer_pkg: shared FSM state type and timing-counter sizing helper
package multi_dac_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SETTLE, LOAD} state_t;
  function automatic int cnt_width(int a, int b, int c, int d, int e);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    m = m > e ? m : e;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/multi_dac_sequencer_if.sv
// multi_dac_sequencer_if: request side and DAC pin side of the sequencer
interface multi_dac_sequencer_if #(parameter int N = 8, parameter int DATA_W = 12);
  localparam int IW = $clog2(N);
  logic in_valid;
  logic in_ready;
  logic in_broadcast;
  logic [IW-1:0] in_index;
  logic [DATA_W-1:0] in_data;
  logic sync_mode;
  logic commit;
  logic [DATA_W-1:0] dac_out;
  logic wr;
  logic [N-1:0] cs_n;
  logic ldac_n;
  logic [N-1:0] pending;
  logic busy;
  logic done;
  modport master (
    output in_valid, in_broadcast, in_index, in_data, sync_mode, commit,
    input in_ready, dac_out, wr, cs_n, ldac_n, pending, busy, done
  );
  modport slave (
    input in_valid, in_broadcast, in_index, in_data, sync_mode, commit,
    output in_ready, dac_out, wr, cs_n, ldac_n, pending, busy, done
  );
endinterface

// File: rtl/multi_dac_sequencer_rr_arbiter.sv
// rr_arbiter: grants the first request after the pointer, wrapping N-1 -> 0
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = ptr_i;
    for (int i = 0; i < N; i++) begin
      j = (j == IW'(N - 1)) ? '0 : j + IW'(1);
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/multi_dac_sequencer.sv
// multi_dac_sequencer: shadowed round-robin writer for N DACs on a shared bus,
// with programmable setup/strobe/hold/settle timing and per-write or committed LDAC
module multi_dac_sequencer
  import multi_dac_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_W = 12,
  parameter int SETUP_CYCLES = 1,
  parameter int WR_CYCLES = 1,
  parameter int HOLD_CYCLES = 1,
  parameter int SETTLE_CYCLES = 10,
  parameter int LDAC_CYCLES = 1
) (
  input logic clk,
  input logic reset_n,
  multi_dac_sequencer_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(SETUP_CYCLES, WR_CYCLES, HOLD_CYCLES, SETTLE_CYCLES, LDAC_CYCLES);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] pend_q, pend_d, gnt, gnt_q, gnt_d, cs_n_q;
  logic [IW-1:0] idx, ptr_q;
  logic [DATA_W-1:0] shd_q [N];
  logic [DATA_W-1:0] shd_d [N];
  logic [DATA_W-1:0] dac_q;
  logic commit_q, commit_d, start, acc, last;
  logic wr_q, ldac_n_q, done_q, busy_q, ready_q;

  rr_arbiter #(.N(N)) u_arb (.req_i(pend_q), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(idx));

  function automatic logic [CW-1:0] plen(state_t s);
    return s == SETUP ? CW'(SETUP_CYCLES) : s == STROBE ? CW'(WR_CYCLES) :
           s == HOLD ? CW'(HOLD_CYCLES) : s == SETTLE ? CW'(SETTLE_CYCLES) :
           s == LOAD ? CW'(LDAC_CYCLES) : '0;
  endfunction

  assign acc = bus.in_valid && ready_q;
  assign start = state_q == IDLE && |pend_q;
  assign last = cnt_q == CW'(1);
  assign gnt_d = start ? gnt : gnt_q;
  assign commit_d = (bus.commit && bus.sync_mode) || (commit_q && !(state_q == LOAD && last));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SETUP : (commit_q && bus.sync_mode) ? LOAD : IDLE;
      SETUP:   state_d = last ? STROBE : SETUP;
      STROBE:  state_d = last ? HOLD : STROBE;
      HOLD:    state_d = last ? SETTLE : HOLD;
      SETTLE:  state_d = last ? (bus.sync_mode ? IDLE : LOAD) : SETTLE;
      LOAD:    state_d = last ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? plen(state_d) : cnt_q - CW'(1);
  end

  // A new request to the channel being launched re-arms its pending bit.
  always_comb begin
    pend_d = start ? pend_q & ~gnt : pend_q;
    shd_d = shd_q;
    for (int i = 0; i < N; i++) begin
      if (acc && (bus.in_broadcast || bus.in_index == IW'(i))) begin
        pend_d[i] = 1'b1;
        shd_d[i] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      gnt_q <= '0;
      ptr_q <= IW'(N - 1);
      shd_q <= '{default: '0};
      dac_q <= '0;
      commit_q <= 1'b0;
      wr_q <= 1'b0;
      cs_n_q <= '1;
      ldac_n_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      gnt_q <= gnt_d;
      shd_q <= shd_d;
      commit_q <= commit_d;
      if (start) begin
        ptr_q <= idx;
        dac_q <= shd_q[idx];
      end
      wr_q <= state_d == STROBE;
      cs_n_q <= (state_d inside {SETUP, STROBE, HOLD}) ? ~gnt_d : '1;
      ldac_n_q <= state_d != LOAD;
      done_q <= state_d == LOAD && cnt_d == CW'(1);
      busy_q <= state_d != IDLE || |pend_d || commit_d;
      ready_q <= state_d != LOAD;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.dac_out = dac_q;
  assign bus.wr = wr_q;
  assign bus.cs_n = cs_n_q;
  assign bus.ldac_n = ldac_n_q;
  assign bus.pending = pend_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_multi_dac_sequencer.sv
// tb_multi_dac_sequencer: directed stimulus with a queue of expected bus writes checked by a pin monitor
module tb_multi_dac_sequencer;
  typedef struct {int idx; int dat;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int ldac_cnt = 0;
  int done_cnt = 0;
  int ld_wr = 0;
  exp_t q[$];
  exp_t e;
  bit in_win = 0;
  bit in_ld = 0;
  bit w_stable;
  logic [3:0] w_cs;
  logic [11:0] w_dat;
  int w_len, w_wr, w_wst, ld_len;

  multi_dac_sequencer_if #(.N(4), .DATA_W(12)) bus ();
  multi_dac_sequencer #(.N(4), .DATA_W(12), .SETUP_CYCLES(1), .WR_CYCLES(2), .HOLD_CYCLES(1),
    .SETTLE_CYCLES(3), .LDAC_CYCLES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_wr(input int idx, input int dat);
    exp_t x;
    x.idx = idx;
    x.dat = dat;
    q.push_back(x);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.commit = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    q.delete();
  endtask

  task automatic send(input logic bc, input int idx, input int dat, output int waits);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_broadcast = bc;
    bus.in_index = 2'(idx);
    bus.in_data = 12'(dat);
    waits = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!ok && waits < 50);
    check("accept_timeout", int'(ok), 1);
    bus.in_valid = 1'b0;
    bus.in_broadcast = 1'b0;
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!bus.wr && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wr_timeout", int'(bus.wr), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 300);
    check("idle_timeout", int'(bus.busy), 0);
    check("queue_drained", q.size(), 0);
  endtask

  // Monitor: one scoreboard pop per completed chip-select window
  always @(negedge clk) begin
    if (!reset_n) begin
      in_win = 0;
      in_ld = 0;
    end else begin
      if (bus.cs_n != 4'hF) begin
        if (!in_win) begin
          in_win = 1;
          w_cs = bus.cs_n;
          w_dat = bus.dac_out;
          w_len = 0;
          w_wr = 0;
          w_wst = -1;
          w_stable = 1;
        end
        if (bus.cs_n != w_cs || bus.dac_out != w_dat) w_stable = 0;
        if (bus.wr) begin
          w_wr++;
          if (w_wst < 0) w_wst = w_len;
        end
        w_len++;
      end else if (in_win) begin
        in_win = 0;
        wr_cnt++;
        check("write_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("wr_cs_n", int'(w_cs), int'(4'hF ^ (4'h1 << e.idx)));
          check("wr_data", int'(w_dat), e.dat);
          check("wr_cs_len", w_len, 4);
          check("wr_strobe_len", w_wr, 2);
          check("wr_strobe_start", w_wst, 1);
          check("wr_stable", int'(w_stable), 1);
        end
      end
      if (!bus.ldac_n) begin
        if (!in_ld) begin
          in_ld = 1;
          ld_len = 0;
          ldac_cnt++;
          ld_wr = wr_cnt;
        end
        ld_len++;
      end else if (in_ld) begin
        in_ld = 0;
        check("ldac_width", ld_len, 2);
      end
      if (bus.done) begin
        done_cnt++;
        check("done_in_ldac", int'(bus.ldac_n), 0);
      end
    end
  end

  initial begin
    int w, wb, lb, db;
    bus.in_valid = 1'b0;
    bus.in_broadcast = 1'b0;
    bus.in_index = '0;
    bus.in_data = '0;
    bus.sync_mode = 1'b0;
    bus.commit = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_cs_n", int'(bus.cs_n), 'hF);
    check("rst_wr", int'(bus.wr), 0);
    check("rst_ldac_n", int'(bus.ldac_n), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_dac_out", int'(bus.dac_out), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    lb = ldac_cnt;
    db = done_cnt;
    expect_wr(2, 'hABC);
    @(posedge clk);
    #1;
    send(1'b0, 2, 'hABC, w);
    @(negedge clk);
    check("lat_idle_cs_n", int'(bus.cs_n), 'hF);
    check("single_pend_set", int'(bus.pending), 'h4);
    @(negedge clk);
    check("lat_cs_n", int'(bus.cs_n), 'hB);
    wait_idle();
    check("single_ldac", ldac_cnt - lb, 1);
    check("single_done", done_cnt - db, 1);
    check("single_pend_clr", int'(bus.pending), 0);

    do_reset();
    bus.sync_mode = 1'b1;
    for (int i = 0; i < 4; i++) expect_wr(i, 'h123);
    wb = wr_cnt;
    lb = ldac_cnt;
    db = done_cnt;
    send(1'b1, 0, 'h123, w);
    bus.commit = 1'b1;
    @(posedge clk);
    #1;
    bus.commit = 1'b0;
    wait_idle();
    check("bc_ldac_count", ldac_cnt - lb, 1);
    check("bc_ldac_after_all", ld_wr - wb, 4);
    check("bc_done", done_cnt - db, 1);
    bus.sync_mode = 1'b0;

    do_reset();
    expect_wr(1, 'h0A1);
    expect_wr(3, 'h0A3);
    expect_wr(0, 'h0A0);
    lb = ldac_cnt;
    send(1'b0, 1, 'h0A1, w);
    wait_wr();
    send(1'b0, 0, 'h0A0, w);
    send(1'b0, 3, 'h0A3, w);
    wait_idle();
    check("rr_ldac", ldac_cnt - lb, 3);

    do_reset();
    expect_wr(1, 'h111);
    expect_wr(1, 'h555);
    send(1'b0, 1, 'h111, w);
    wait_wr();
    for (int i = 0; i < 10 && bus.wr; i++) begin
      @(posedge clk);
      #1;
    end
    check("coll_hold_cs_n", int'(bus.cs_n), 'hD);
    send(1'b0, 1, 'h555, w);
    @(negedge clk);
    check("coll_pend", int'(bus.pending), 'h2);
    wait_idle();

    do_reset();
    wb = wr_cnt;
    db = done_cnt;
    send(1'b0, 2, 'h777, w);
    wait_wr();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_wr", int'(bus.wr), 0);
    check("abort_cs_n", int'(bus.cs_n), 'hF);
    check("abort_pending", int'(bus.pending), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_ldac_n", int'(bus.ldac_n), 1);
    repeat (20) @(negedge clk);
    check("abort_no_write", wr_cnt - wb, 0);
    check("abort_no_done", done_cnt - db, 0);

    do_reset();
    expect_wr(0, 'h0B0);
    expect_wr(1, 'h0B1);
    send(1'b0, 0, 'h0B0, w);
    for (int i = 0; i < 60 && bus.ldac_n; i++) begin
      @(posedge clk);
      #1;
    end
    check("load_seen", int'(bus.ldac_n), 0);
    check("ready_in_load", int'(bus.in_ready), 0);
    send(1'b0, 1, 'h0B1, w);
    check("accept_first_idle", w, 3);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
